// File: rtl/calc_sequencer_if.sv
// Button inputs and capture-state outputs between the board, the sequencer and the input register/display.
interface calc_sequencer_if;
   logic       BTN_ENTER;
   logic       BTN_UNDO;
   logic [1:0] STATE;
   logic [3:0] STATE_LED;
   logic       RESULT_VALID;
   logic       ENTER_PULSE;
   logic       UNDO_PULSE;

   modport master (
      input  BTN_ENTER, BTN_UNDO,
      output STATE, STATE_LED, RESULT_VALID, ENTER_PULSE, UNDO_PULSE
   );

   modport slave (
      output BTN_ENTER, BTN_UNDO,
      input  STATE, STATE_LED, RESULT_VALID, ENTER_PULSE, UNDO_PULSE
   );
endinterface

// File: rtl/calc_sequencer.sv
// Calculator input-path sequencer: debounces ENTER/UNDO and steps the A -> B -> OP -> RESULT capture state.
module calc_sequencer #(
   parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
   input  logic              CLK,
   input  logic              RESET,
   calc_sequencer_if.master  bus
);

   localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   typedef enum logic [1:0] {
      ST_A      = 2'd0,
      ST_B      = 2'd1,
      ST_OP     = 2'd2,
      ST_RESULT = 2'd3
   } state_t;

   // Index 0 = ENTER, index 1 = UNDO
   logic [1:0]       btn_raw;
   logic [1:0]       sync1_q;
   logic [1:0]       sync2_q;
   logic [1:0]       db_q;
   logic [1:0]       pulse_q;
   logic [CNT_W-1:0] cnt_q [2];
   logic [1:0]       accept_c;
   logic [1:0]       rise_c;

   state_t     state_q, state_d;
   logic [3:0] led_q, led_d;
   logic       valid_q, valid_d;

   assign btn_raw = {bus.BTN_UNDO, bus.BTN_ENTER};

   // A level change is accepted on the DEBOUNCE_CYCLES-th consecutive differing sample
   always_comb begin
      accept_c = '0;
      rise_c   = '0;
      for (int i = 0; i < 2; i++) begin
         accept_c[i] = (sync2_q[i] != db_q[i]) && (cnt_q[i] == CNT_LAST);
         rise_c[i]   = accept_c[i] & sync2_q[i];
      end
   end

   always_ff @(posedge CLK) begin
      if (!RESET) begin
         sync1_q <= '0;
         sync2_q <= '0;
         db_q    <= '0;
         pulse_q <= '0;
         for (int i = 0; i < 2; i++) cnt_q[i] <= '0;
      end else begin
         sync1_q <= btn_raw;
         sync2_q <= sync1_q;
         pulse_q <= rise_c;
         for (int i = 0; i < 2; i++) begin
            if (sync2_q[i] == db_q[i]) begin
               cnt_q[i] <= '0;
            end else if (accept_c[i]) begin
               db_q[i]  <= sync2_q[i];
               cnt_q[i] <= '0;
            end else begin
               cnt_q[i] <= cnt_q[i] + CNT_W'(1);
            end
         end
      end
   end

   always_ff @(posedge CLK) begin
      if (!RESET) begin
         state_q <= ST_A;
         led_q   <= 4'b0001;
         valid_q <= 1'b0;
      end else begin
         state_q <= state_d;
         led_q   <= led_d;
         valid_q <= valid_d;
      end
   end

   // Decodes are built from the next state so they move together with STATE
   always_comb begin
      state_d = state_q;
      case (pulse_q)
         2'b01: state_d = state_t'(state_q + 2'd1);
         2'b10: if (state_q != ST_A) state_d = state_t'(state_q - 2'd1);
         default: state_d = state_q;
      endcase
      led_d   = 4'(1) << state_d;
      valid_d = (state_d == ST_RESULT);
   end

   assign bus.STATE        = state_q;
   assign bus.STATE_LED    = led_q;
   assign bus.RESULT_VALID = valid_q;
   assign bus.ENTER_PULSE  = pulse_q[0];
   assign bus.UNDO_PULSE   = pulse_q[1];

endmodule

// File: tb/tb_calc_sequencer.sv
// Directed bench for calc_sequencer with a scoreboard of expected STATE transitions.
module tb_calc_sequencer;

   logic CLK;
   logic RESET;
   calc_sequencer_if bus_if ();

   calc_sequencer #(.DEBOUNCE_CYCLES(4)) dut (
      .CLK   (CLK),
      .RESET (RESET),
      .bus   (bus_if)
   );

   int checks = 0;
   int errors = 0;
   int enter_cnt = 0;
   int undo_cnt = 0;
   logic [1:0] exp_q [$];
   logic [1:0] prev_state;

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge CLK);
         #1;
      end
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Scoreboard side: every STATE change must match the next queued expectation
   always @(negedge CLK) begin
      if (bus_if.ENTER_PULSE === 1'b1) enter_cnt++;
      if (bus_if.UNDO_PULSE === 1'b1) undo_cnt++;
      if (!$isunknown(prev_state) && bus_if.STATE !== prev_state) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $error("FAIL unexpected_state_change observed=%0d expected=none", bus_if.STATE);
         end else begin
            logic [1:0] e;
            e = exp_q.pop_front();
            assert (bus_if.STATE === e) else begin
               errors++;
               $error("FAIL state_seq observed=%0d expected=%0d", bus_if.STATE, e);
            end
         end
      end
      prev_state = bus_if.STATE;
   end

   // One full press/release with latency checks; change=0 means the press must not move STATE
   task automatic press(input bit undo, input logic [1:0] from, input logic [1:0] to, input bit change);
      if (change) exp_q.push_back(to);
      if (undo) bus_if.BTN_UNDO = 1'b1; else bus_if.BTN_ENTER = 1'b1;
      tick(5);
      chk("pulse_early", undo ? bus_if.UNDO_PULSE : bus_if.ENTER_PULSE, 0);
      tick(1);
      chk("pulse_high", undo ? bus_if.UNDO_PULSE : bus_if.ENTER_PULSE, 1);
      chk("state_before", bus_if.STATE, from);
      tick(1);
      chk("state_after", bus_if.STATE, to);
      chk("led_after", bus_if.STATE_LED, 4'b0001 << to);
      chk("valid_after", bus_if.RESULT_VALID, (to == 2'd3));
      chk("pulse_low", undo ? bus_if.UNDO_PULSE : bus_if.ENTER_PULSE, 0);
      tick(3);
      if (undo) bus_if.BTN_UNDO = 1'b0; else bus_if.BTN_ENTER = 1'b0;
      tick(10);
   endtask

   initial begin
      int e0;
      int u0;
      prev_state = 'x;
      RESET = 1'b0;
      bus_if.BTN_ENTER = 1'b0;
      bus_if.BTN_UNDO  = 1'b0;
      tick(3);
      chk("rst_state", bus_if.STATE, 0);
      chk("rst_led", bus_if.STATE_LED, 4'b0001);
      chk("rst_valid", bus_if.RESULT_VALID, 0);
      chk("rst_enter_pulse", bus_if.ENTER_PULSE, 0);
      chk("rst_undo_pulse", bus_if.UNDO_PULSE, 0);
      RESET = 1'b1;
      tick(1);

      // Walk 0 -> 1 -> 2 -> 3 -> 0
      press(0, 2'd0, 2'd1, 1);
      press(0, 2'd1, 2'd2, 1);
      press(0, 2'd2, 2'd3, 1);
      press(0, 2'd3, 2'd0, 1);

      // Bounce rejection followed by a stable press
      e0 = enter_cnt;
      for (int i = 0; i < 5; i++) begin
         bus_if.BTN_ENTER = 1'b1;
         tick(2);
         bus_if.BTN_ENTER = 1'b0;
         tick(2);
      end
      tick(2);
      chk("bounce_no_pulse", enter_cnt - e0, 0);
      chk("bounce_state_hold", bus_if.STATE, 0);
      exp_q.push_back(2'd1);
      bus_if.BTN_ENTER = 1'b1;
      tick(10);
      chk("bounce_one_pulse", enter_cnt - e0, 1);
      chk("bounce_state", bus_if.STATE, 1);
      bus_if.BTN_ENTER = 1'b0;
      tick(10);

      // Held button
      e0 = enter_cnt;
      exp_q.push_back(2'd2);
      bus_if.BTN_ENTER = 1'b1;
      tick(100);
      chk("held_one_pulse", enter_cnt - e0, 1);
      chk("held_state", bus_if.STATE, 2);
      bus_if.BTN_ENTER = 1'b0;
      tick(10);

      // Undo 2 -> 1 -> 0, then ignored in 0
      u0 = undo_cnt;
      press(1, 2'd2, 2'd1, 1);
      press(1, 2'd1, 2'd0, 1);
      press(1, 2'd0, 2'd0, 0);
      chk("undo_pulses", undo_cnt - u0, 3);
      chk("undo_state", bus_if.STATE, 0);

      // Simultaneous ENTER and UNDO from state 1
      press(0, 2'd0, 2'd1, 1);
      bus_if.BTN_ENTER = 1'b1;
      bus_if.BTN_UNDO  = 1'b1;
      tick(6);
      chk("simul_enter_pulse", bus_if.ENTER_PULSE, 1);
      chk("simul_undo_pulse", bus_if.UNDO_PULSE, 1);
      tick(10);
      chk("simul_state", bus_if.STATE, 1);
      bus_if.BTN_ENTER = 1'b0;
      bus_if.BTN_UNDO  = 1'b0;
      tick(10);

      // Reset in the middle of a debounce from state 3
      press(0, 2'd1, 2'd2, 1);
      press(0, 2'd2, 2'd3, 1);
      e0 = enter_cnt;
      exp_q.push_back(2'd0);
      bus_if.BTN_ENTER = 1'b1;
      tick(2);
      RESET = 1'b0;
      tick(1);
      chk("midrst_state", bus_if.STATE, 0);
      chk("midrst_led", bus_if.STATE_LED, 4'b0001);
      chk("midrst_valid", bus_if.RESULT_VALID, 0);
      RESET = 1'b1;
      exp_q.push_back(2'd1);
      tick(5);
      chk("midrst_pulse_early", bus_if.ENTER_PULSE, 0);
      tick(1);
      chk("midrst_pulse", bus_if.ENTER_PULSE, 1);
      chk("midrst_state_hold", bus_if.STATE, 0);
      tick(1);
      chk("midrst_state_new", bus_if.STATE, 1);
      chk("midrst_led_new", bus_if.STATE_LED, 4'b0010);
      bus_if.BTN_ENTER = 1'b0;
      tick(10);
      chk("midrst_pulse_count", enter_cnt - e0, 1);

      tick(2);
      chk("scoreboard_empty", exp_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/calc_sequencer.md
# calc_sequencer

Control FSM for the calculator input path. Debounces two board push-buttons (ENTER, UNDO) and walks the 2-bit operand-capture state A → B → OP → RESULT → A. Drives the STATE bus of the operand/operation input register and the result-display enable. Sits between the board buttons and the input register/ALU/display.

## Interface
- DEBOUNCE_CYCLES, 500000, number of consecutive identical synchronized samples required to accept a button level change (5 ms at 100 MHz); legal range ≥ 2.

- CLK  in  1  system clock, all logic on rising edge.
- RESET  in  1  synchronous, active-low reset.
- BTN_ENTER  in  1  raw, asynchronous, bouncing push-button; high = pressed.
- BTN_UNDO  in  1  raw, asynchronous, bouncing push-button; high = pressed.
- STATE  out  2  capture state to the input register: 0 = load A, 1 = load B, 2 = load OP, 3 = result.
- STATE_LED  out  4  one-hot copy of STATE (bit n high when STATE == n).
- RESULT_VALID  out  1  high while STATE == 3; enables the result on the display.
- ENTER_PULSE  out  1  one-cycle strobe per accepted ENTER press.
- UNDO_PULSE  out  1  one-cycle strobe per accepted UNDO press.

## Operation
- Reset (RESET low at a rising edge): STATE = 0, STATE_LED = 4'b0001, RESULT_VALID = 0, ENTER_PULSE = 0, UNDO_PULSE = 0. Synchronizers, debounced levels and counters clear to 0. Any debounce in progress is discarded.
- Per button, identical and independent:
  - 2-flop synchronizer, then debouncer.
  - The debouncer holds a debounced level DB (reset 0) and a counter of width $clog2(DEBOUNCE_CYCLES).
  - If the synchronized sample equals DB: the counter clears.
  - Otherwise the counter increments. On the DEBOUNCE_CYCLES-th consecutive differing sample, DB takes the new value and the counter clears.
  - A 0→1 transition of DB produces one registered pulse (ENTER_PULSE / UNDO_PULSE). A 1→0 transition produces nothing.
  - A button held down gives exactly one pulse. A new pulse requires an accepted release (DB back to 0) first.
  - A button already held when reset releases is accepted as a press, since DB restarts at 0.
- FSM, evaluated on the pulses:
  - ENTER only: 0→1, 1→2, 2→3, 3→0 (wrap; a new calculation starts).
  - UNDO only: 1→0, 2→1, 3→2. In state 0, UNDO is ignored.
  - ENTER and UNDO pulses in the same cycle: both ignored, STATE unchanged. Both pulses are still output.
  - No pulse: hold.
- The input register loads continuously while STATE selects a field. Leaving a state therefore freezes that field at the value present on the last cycle of the state. The sequencer does not drive data.
- STATE_LED and RESULT_VALID are decoded from the registered STATE. They change in the same cycle as STATE and have no extra latency.

## Timing
- Let t0 be the first rising edge that samples the raw button high, with the button stable from then on.
  - Synchronizer output is valid after edge t0+1.
  - Debouncer samples at edges t0+2 … t0+DEBOUNCE_CYCLES+1; DB rises at edge t0+DEBOUNCE_CYCLES+1.
  - The pulse is high from edge t0+DEBOUNCE_CYCLES+1 to edge t0+DEBOUNCE_CYCLES+2.
  - STATE updates at edge t0+DEBOUNCE_CYCLES+2.
  - Total latency from raw press to new STATE: DEBOUNCE_CYCLES+2 edges.
- A release needs the same DEBOUNCE_CYCLES+2 edges before the next press can start counting.
- Glitches:
  - A raw glitch shorter than DEBOUNCE_CYCLES synchronized samples gives no pulse and leaves STATE unchanged.
  - Any opposite sample mid-count restarts the count from zero.
- Reset mid-operation: outputs take reset values at the first edge with RESET low and hold while it stays low. The first accepted press after release needs the full DEBOUNCE_CYCLES+2 edges.
- Pulse spacing: the minimum interval between two pulses of one button is 2·DEBOUNCE_CYCLES cycles.

## Test plan
- Reset and walk:
  - Stimulus: DEBOUNCE_CYCLES = 4; assert RESET low 3 cycles; press ENTER 10 cycles, release 10 cycles, repeat 4×.
  - Required: STATE goes 0→1→2→3→0. Each change occurs exactly 6 edges after the press is first sampled. RESULT_VALID is high only in state 3. STATE_LED is 0001, 0010, 0100, 1000, 0001.
- Bounce rejection:
  - Stimulus: ENTER toggles high/low every 2 cycles for 20 cycles, then stays high 10 cycles.
  - Required: exactly one ENTER_PULSE, after the stable-high run; STATE 0→1.
- Held button:
  - Stimulus: ENTER held high for 100 cycles.
  - Required: exactly one ENTER_PULSE; STATE advances by exactly 1.
- Undo:
  - Stimulus: from state 2, press UNDO twice, then once more.
  - Required: STATE 2→1→0, then stays 0. Three UNDO_PULSEs are seen.
- Simultaneous:
  - Stimulus: from state 1, press ENTER and UNDO on the same edge.
  - Required: ENTER_PULSE and UNDO_PULSE high in the same cycle; STATE stays 1.
- Reset mid-debounce:
  - Stimulus: from state 3, press ENTER; drive RESET low for 1 cycle 2 edges after the press is sampled, keeping ENTER high.
  - Required: STATE = 0 after the reset edge. One ENTER_PULSE occurs 6 edges after RESET returns high (button treated as a new press). STATE = 1.
